// File: rtl/phy_rx_dqs_aligner.sv
//------------------------------------------------------------------------------
// Module  : phy_rx_dqs_aligner
// Brief   : Locks to the DQS toggle pattern at an even slot offset and emits
//           word-aligned DQ beats until postamble, length completion or glitch.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module phy_rx_dqs_aligner #(
    parameter int LANES   = 4,
    parameter int DQ_BITS = 8,
    parameter int LEN_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_en,
    input  logic [LEN_W-1:0]           i_len,
    input  logic [LANES-1:0]           i_dqs,
    input  logic [LANES*DQ_BITS-1:0]   i_dq,
    output logic                       o_valid,
    output logic [LANES-1:0]           o_dqs,
    output logic [LANES*DQ_BITS-1:0]   o_dq,
    output logic                       o_locked,
    output logic [$clog2(LANES)-1:0]   o_offset,
    output logic [LEN_W-1:0]           o_beat_cnt,
    output logic                       o_done,
    output logic                       o_err
);

    localparam int DQW   = LANES * DQ_BITS;
    localparam int OFF_W = $clog2(LANES);
    localparam logic [LANES-1:0] TOG = {(LANES/2){2'b01}};

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [LANES-1:0]    prev_dqs;
    logic [DQW-1:0]      prev_dq;
    logic [LEN_W-1:0]    len_q;

    logic [2*LANES-1:0]  win_dqs;
    logic [2*DQW-1:0]    win_dq;
    logic [LANES-1:0]    win_locked;

    logic                hit;
    logic [OFF_W-1:0]    hit_off;
    logic [LEN_W-1:0]    cnt_inc;

    logic                valid_nxt;
    logic [DQW-1:0]      dq_nxt;
    logic [OFF_W-1:0]    off_nxt;
    logic [LEN_W-1:0]    cnt_nxt;
    logic [LEN_W-1:0]    len_nxt;
    logic                done_nxt;
    logic                err_nxt;

    assign win_dqs    = {i_dqs, prev_dqs};
    assign win_dq     = {i_dq, prev_dq};
    assign win_locked = win_dqs[o_offset +: LANES];
    assign cnt_inc    = (o_beat_cnt == '1) ? o_beat_cnt : o_beat_cnt + 1'b1;

    // Scan from the top down so the lowest matching offset is the one kept.
    always_comb begin
        hit     = 1'b0;
        hit_off = '0;
        for (int s = LANES - 2; s >= 0; s -= 2) begin
            if (win_dqs[s +: LANES] == TOG) begin
                hit     = 1'b1;
                hit_off = OFF_W'(s);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        valid_nxt = 1'b0;
        dq_nxt    = '0;
        off_nxt   = o_offset;
        cnt_nxt   = o_beat_cnt;
        len_nxt   = len_q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (i_en && hit) begin
                    valid_nxt = 1'b1;
                    dq_nxt    = win_dq[hit_off*DQ_BITS +: DQW];
                    off_nxt   = hit_off;
                    cnt_nxt   = LEN_W'(1);
                    len_nxt   = i_len;
                    // A one-beat transfer is complete with its first beat.
                    if (i_len == LEN_W'(1)) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (!i_en) begin
                    state_nxt = IDLE;
                end else if (win_locked == '0) begin
                    state_nxt = IDLE;
                    if (len_q == '0 || o_beat_cnt == len_q) begin
                        done_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (win_locked == TOG) begin
                    valid_nxt = 1'b1;
                    dq_nxt    = win_dq[o_offset*DQ_BITS +: DQW];
                    cnt_nxt   = cnt_inc;
                    if (len_q != '0 && cnt_inc == len_q) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_dqs   <= '0;
            prev_dq    <= '0;
            len_q      <= '0;
            o_valid    <= 1'b0;
            o_dqs      <= '0;
            o_dq       <= '0;
            o_locked   <= 1'b0;
            o_offset   <= '0;
            o_beat_cnt <= '0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            prev_dqs   <= i_dqs;
            prev_dq    <= i_dq;
            len_q      <= len_nxt;
            o_valid    <= valid_nxt;
            o_dqs      <= valid_nxt ? TOG : '0;
            o_dq       <= dq_nxt;
            o_locked   <= (state_nxt == LOCKED);
            o_offset   <= off_nxt;
            o_beat_cnt <= cnt_nxt;
            o_done     <= done_nxt;
            o_err      <= err_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_phy_rx_dqs_aligner.sv
//------------------------------------------------------------------------------
// Module  : tb_phy_rx_dqs_aligner
// Brief   : Randomized slot-stream bench for phy_rx_dqs_aligner with a
//           slot-array reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_phy_rx_dqs_aligner;

    localparam int LANES   = 4;
    localparam int DQ_BITS = 8;
    localparam int LEN_W   = 16;
    localparam int DQW     = LANES * DQ_BITS;
    localparam int OFF_W   = $clog2(LANES);
    localparam int CNT_MAX = (1 << LEN_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  i_en;
    logic [LEN_W-1:0]      i_len;
    logic [LANES-1:0]      i_dqs;
    logic [DQW-1:0]        i_dq;
    logic                  o_valid;
    logic [LANES-1:0]      o_dqs;
    logic [DQW-1:0]        o_dq;
    logic                  o_locked;
    logic [OFF_W-1:0]      o_offset;
    logic [LEN_W-1:0]      o_beat_cnt;
    logic                  o_done;
    logic                  o_err;

    phy_rx_dqs_aligner #(.LANES(LANES), .DQ_BITS(DQ_BITS), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_len(i_len), .i_dqs(i_dqs),
        .i_dq(i_dq), .o_valid(o_valid), .o_dqs(o_dqs), .o_dq(o_dq),
        .o_locked(o_locked), .o_offset(o_offset), .o_beat_cnt(o_beat_cnt),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: slot-level history and burst bookkeeping.
    bit                 m_prev_s [LANES];
    logic [DQ_BITS-1:0] m_prev_d [LANES];
    bit                 m_locked;
    int                 m_len;
    bit                 e_valid, e_done, e_err;
    logic [DQW-1:0]     e_dq;
    int                 e_off, e_cnt;

    function automatic bit slot_is_tog(input int k);
        return (k % 2) == 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < LANES; k++) begin
            m_prev_s[k] = 1'b0;
            m_prev_d[k] = '0;
        end
        m_locked = 0; m_len = 0;
        e_valid = 0; e_done = 0; e_err = 0; e_dq = '0; e_off = 0; e_cnt = 0;
    endtask

    task automatic model_step();
        bit                 ws [2*LANES];
        logic [DQ_BITS-1:0] wd [2*LANES];
        int                 found;
        bit                 all_zero, is_tog;
        for (int k = 0; k < LANES; k++) begin
            ws[k]         = m_prev_s[k];
            ws[k+LANES]   = i_dqs[k];
            wd[k]         = m_prev_d[k];
            wd[k+LANES]   = i_dq[k*DQ_BITS +: DQ_BITS];
        end
        e_valid = 0; e_done = 0; e_err = 0; e_dq = '0;
        if (rst) begin
            model_reset();
            return;
        end
        if (!m_locked) begin
            found = -1;
            for (int s = 0; s < LANES; s += 2) begin
                is_tog = 1;
                for (int k = 0; k < LANES; k++)
                    if (ws[s+k] != slot_is_tog(k)) is_tog = 0;
                if (found < 0 && is_tog) found = s;
            end
            if (i_en && found >= 0) begin
                e_valid = 1;
                for (int k = 0; k < LANES; k++) e_dq[k*DQ_BITS +: DQ_BITS] = wd[found+k];
                e_off = found; e_cnt = 1; m_len = int'(i_len);
                if (m_len == 1) e_done = 1;
                else m_locked = 1;
            end
        end else begin
            all_zero = 1; is_tog = 1;
            for (int k = 0; k < LANES; k++) begin
                if (ws[e_off+k]) all_zero = 0;
                if (ws[e_off+k] != slot_is_tog(k)) is_tog = 0;
            end
            if (!i_en) begin
                m_locked = 0;
            end else if (all_zero) begin
                m_locked = 0;
                if (m_len == 0 || e_cnt == m_len) e_done = 1;
                else e_err = 1;
            end else if (is_tog) begin
                e_valid = 1;
                for (int k = 0; k < LANES; k++) e_dq[k*DQ_BITS +: DQ_BITS] = wd[e_off+k];
                if (e_cnt < CNT_MAX) e_cnt++;
                if (m_len != 0 && e_cnt == m_len) begin
                    e_done = 1; m_locked = 0;
                end
            end else begin
                e_err = 1; m_locked = 0;
            end
        end
        for (int k = 0; k < LANES; k++) begin
            m_prev_s[k] = i_dqs[k];
            m_prev_d[k] = i_dq[k*DQ_BITS +: DQ_BITS];
        end
    endtask

    task automatic check_outputs();
        check("valid",  64'(o_valid),    64'(e_valid));
        check("dqs",    64'(o_dqs),      e_valid ? 64'h5 : 64'h0);
        check("dq",     64'(o_dq),       64'(e_dq));
        check("locked", 64'(o_locked),   64'(m_locked));
        check("offset", 64'(o_offset),   64'(e_off));
        check("cnt",    64'(o_beat_cnt), 64'(e_cnt));
        check("done",   64'(o_done),     64'(e_done));
        check("err",    64'(o_err),      64'(e_err));
    endtask

    // Slot stream feeding i_dqs, LANES slots per cycle, oldest first.
    bit q_slots [$];

    task automatic push_gap(input int n);
        for (int i = 0; i < n; i++) q_slots.push_back(1'b0);
    endtask

    task automatic push_burst(input int beats, input bit glitch);
        int gpos;
        gpos = glitch ? $urandom_range(beats*LANES-1, 0) : -1;
        for (int i = 0; i < beats*LANES; i++)
            q_slots.push_back(slot_is_tog(i % LANES) ^ (i == gpos));
    endtask

    task automatic cycle(input bit r, input bit en);
        rst  = r;
        i_en = en;
        for (int k = 0; k < LANES; k++)
            i_dqs[k] = (q_slots.size() > 0) ? q_slots.pop_front() : 1'b0;
        i_dq = $urandom;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic drain();
        while (q_slots.size() > 0) cycle(1'b0, 1'b1);
    endtask

    initial begin
        int n;
        model_reset();
        rst = 1'b1; i_en = 1'b0; i_len = '0; i_dqs = '0; i_dq = '0;
        @(posedge clk); @(posedge clk);
        #1;
        check_outputs();

        // Offset 0, exact length.
        i_len = 16'd4; push_gap(4); push_burst(4, 0); push_gap(4); drain();
        // Offset 2, straddling words, exact length.
        i_len = 16'd3; push_gap(6); push_burst(3, 0); push_gap(6); drain();
        // Short burst against a longer length.
        i_len = 16'd8; push_gap(4); push_burst(5, 0); push_gap(8); drain();
        // Unlimited length, long burst.
        i_len = 16'd0; push_gap(4); push_burst(300, 0); push_gap(8); drain();
        // Glitch then clean re-lock.
        i_len = 16'd0; push_gap(4); push_burst(3, 0);
        q_slots.push_back(1); q_slots.push_back(1); q_slots.push_back(1); q_slots.push_back(0);
        push_burst(3, 0); push_gap(4); drain();
        // Back-to-back bursts with exact lengths.
        i_len = 16'd2; push_gap(4); push_burst(2, 0); push_burst(2, 0); push_gap(4); drain();
        // Reset and enable drop mid-burst.
        i_len = 16'd0; push_gap(4); push_burst(10, 0);
        repeat (4) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        push_gap(4); drain();

        // Randomized bursts.
        for (int b = 0; b < 200; b++) begin
            n = $urandom_range(12, 1);
            case ($urandom_range(3, 0))
                0: i_len = '0;
                1: i_len = LEN_W'(n);
                2: i_len = LEN_W'(n + $urandom_range(3, 1));
                default: i_len = LEN_W'($urandom_range(n, 1));
            endcase
            push_gap(($urandom_range(3, 0) == 0) ? $urandom_range(7, 0) : 2 * $urandom_range(4, 0));
            push_burst(n, $urandom_range(7, 0) == 0);
            while (q_slots.size() >= LANES)
                cycle($urandom_range(399, 0) == 0, $urandom_range(99, 0) != 0);
        end
        push_gap(8); drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
